// File: rtl/lpf_ch_sched.sv
// lpf_ch_sched: time-shares one low-pass filter between the L and R sample streams
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   smpl_in_rdy_l/smpl_in_l            left sample strobe/data from generator
//   smpl_in_rdy_r/smpl_in_r            right sample strobe/data from generator
//   flt_smpl_in_rdy/flt_smpl_in        sample issued to the shared filter
//   flt_ch_sel                         channel of current job (0=L, 1=R)
//   flt_smpl_out_rdy/flt_smpl_out      result strobe/data from the filter
//   smpl_out_rdy_l/smpl_out_l          filtered left sample strobe/held data
//   smpl_out_rdy_r/smpl_out_r          filtered right sample strobe/held data
//   busy, err_overrun, err_timeout     status and sticky error flags
module lpf_ch_sched #(
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              smpl_in_rdy_l,
  input  logic [DATA_W-1:0] smpl_in_l,
  input  logic              smpl_in_rdy_r,
  input  logic [DATA_W-1:0] smpl_in_r,
  output logic              flt_smpl_in_rdy,
  output logic [DATA_W-1:0] flt_smpl_in,
  output logic              flt_ch_sel,
  input  logic              flt_smpl_out_rdy,
  input  logic [DATA_W-1:0] flt_smpl_out,
  output logic              smpl_out_rdy_l,
  output logic [DATA_W-1:0] smpl_out_l,
  output logic              smpl_out_rdy_r,
  output logic [DATA_W-1:0] smpl_out_r,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic              pend_l, pend_r, last_ch;
  logic [TW-1:0]     timer;
  logic              issue_l, issue_r, done, expire;
  assign issue_l         = state == ISSUE && !flt_ch_sel;
  assign issue_r         = state == ISSUE && flt_ch_sel;
  assign done            = state == WAIT && flt_smpl_out_rdy;
  assign expire          = state == WAIT && !flt_smpl_out_rdy && timer == TW'(TIMEOUT);
  assign flt_smpl_in_rdy = state == ISSUE;
  // The buffer is read during ISSUE; a capture in that same cycle lands after the read.
  assign flt_smpl_in     = flt_ch_sel ? hold_r : hold_l;
  assign busy            = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      hold_l         <= '0;
      hold_r         <= '0;
      pend_l         <= 1'b0;
      pend_r         <= 1'b0;
      last_ch        <= 1'b1;
      timer          <= '0;
      flt_ch_sel     <= 1'b0;
      smpl_out_rdy_l <= 1'b0;
      smpl_out_rdy_r <= 1'b0;
      smpl_out_l     <= '0;
      smpl_out_r     <= '0;
      err_overrun    <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      if (smpl_in_rdy_l) hold_l <= smpl_in_l;
      if (smpl_in_rdy_r) hold_r <= smpl_in_r;
      // A capture coinciding with its own issue keeps the channel pending for the new sample.
      pend_l <= smpl_in_rdy_l || (pend_l && !issue_l);
      pend_r <= smpl_in_rdy_r || (pend_r && !issue_r);
      if ((smpl_in_rdy_l && pend_l && !issue_l) || (smpl_in_rdy_r && pend_r && !issue_r))
        err_overrun <= 1'b1;
      if (expire) err_timeout <= 1'b1;
      smpl_out_rdy_l <= done && !flt_ch_sel;
      smpl_out_rdy_r <= done && flt_ch_sel;
      if (done && !flt_ch_sel) smpl_out_l <= flt_smpl_out;
      if (done && flt_ch_sel) smpl_out_r <= flt_smpl_out;
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (state == IDLE && (pend_l || pend_r)) begin
        flt_ch_sel <= pend_l && pend_r ? !last_ch : pend_r;
        state      <= ISSUE;
      end
      if (state == ISSUE) begin
        last_ch <= flt_ch_sel;
        state   <= WAIT;
      end
      if (done || expire) state <= IDLE;
    end
endmodule
